capture_readout: RTL and testbench
==================================

CAPTURE_READOUT -- requirements
Module: capture_readout

Interface
REQ-001 Parameter ADDR_W, default 18, BRAM address width (262144 samples).
REQ-002 Parameter DATA_W, default 8, sample width (one bit per probe channel).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle pulse; begins a readout when idle.
REQ-006 abort  input  1  terminates an active readout.
REQ-007 length  input  ADDR_W+1  sample count to read, from address 0; sampled on the accepted start.
REQ-008 bram_en  output  1  BRAM read enable.
REQ-009 bram_addr  output  ADDR_W  BRAM read address.
REQ-010 bram_dout  input  DATA_W  BRAM read data, valid exactly 1 cycle after the bram_en cycle.
REQ-011 m_data  output  DATA_W  stream data to host link.
REQ-012 m_valid  output  1  stream data valid.
REQ-013 m_ready  input  1  stream sink ready; transfer occurs when m_valid and m_ready are both high.
REQ-014 busy  output  1  high from accepted start until completion or abort.
REQ-015 done  output  1  one-cycle pulse on normal completion.
REQ-016 sent_count  output  ADDR_W+1  transfers completed in the current or last readout.

Function
REQ-017 States: IDLE, READ, DRAIN.
REQ-018 IDLE: start=1 -> latch length, clear sent_count and read pointer, busy=1, go to READ; start ignored while busy.
REQ-019 length clamped to 2^ADDR_W; length=0 -> no BRAM read, no stream transfer, done pulses the cycle after start, busy stays 0, state returns to IDLE.
REQ-020 Output buffer: 2-entry FIFO feeding m_data/m_valid; m_data = head entry; m_valid = FIFO non-empty.
REQ-021 READ: bram_en=1 in a cycle only when (FIFO occupancy + reads in flight) < 2 and issued reads < length; bram_addr = read pointer; pointer increments by 1 per issued read.
REQ-022 bram_dout captured into FIFO tail the cycle after each bram_en cycle; the FIFO never overflows and no sample is dropped or duplicated.
REQ-023 Simultaneous FIFO push and pop permitted; occupancy unchanged.
REQ-024 Sustained throughput with m_ready held high: one transfer per clock after a 2-cycle start-up latency (start accepted in cycle N -> first bram_en in cycle N+1 -> first m_valid in cycle N+2).
REQ-025 m_data and m_valid SHALL hold stable while m_valid=1 and m_ready=0.
REQ-026 READ -> DRAIN when issued reads = length; DRAIN -> IDLE when FIFO empty and no read in flight; on that transition done=1 for one cycle and busy=0.
REQ-027 sent_count increments by 1 per transfer; saturates at latched length; holds value in IDLE.
REQ-028 Read pointer reaching 2^ADDR_W-1 and issuing is the last possible read; pointer never wraps to 0 within a readout.
REQ-029 abort=1 in READ or DRAIN: next cycle state=IDLE, FIFO flushed, in-flight data discarded, m_valid=0, busy=0, done not pulsed, sent_count holds; abort in IDLE ignored.
REQ-030 start and abort in the same cycle: abort wins; no readout begins.
REQ-031 bram_en=0 in IDLE and DRAIN.

Reset
REQ-032 resetn=0 forces asynchronously: state=IDLE, bram_en=0, bram_addr=0, m_valid=0, m_data=0, busy=0, done=0, sent_count=0, FIFO empty, in-flight flag cleared.
REQ-033 Reset mid-readout discards all buffered data; no transfer occurs until a new start after resetn deasserts.

Verification
REQ-034 BRAM model with addr->data = addr[7:0], length=5, m_ready=1 -> m_data 0,1,2,3,4 on consecutive cycles starting 2 cycles after start; done 1 cycle after last transfer; sent_count=5.
REQ-035 length=8, m_ready toggling 1,0,0,1 repeating -> exactly 8 transfers, values 0..7 in order, m_data stable during stalls, bram_en never issued with 2 entries buffered.
REQ-036 length=0 -> no bram_en, no m_valid, done pulse the cycle after start, sent_count=0.
REQ-037 length=262144 with m_ready=1 -> last bram_addr=262143, 262144 transfers, pointer never returns to 0, single done.
REQ-038 abort after 3 transfers with m_ready=0 and FIFO full -> m_valid=0 next cycle, busy=0, no done, sent_count=3; following start with length=2 yields 0,1.
REQ-039 resetn pulsed low mid-READ -> all outputs at reset values immediately; start pulses while busy and start+abort same cycle both ignored.

Source files
------------

// File: rtl/capture_readout_if.sv
// capture_readout_if: BRAM read port and output stream of the capture readout engine
interface capture_readout_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
);
  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_dout;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  modport master (output bram_en, bram_addr, m_data, m_valid, input bram_dout, m_ready);
  modport slave (input bram_en, bram_addr, m_data, m_valid, output bram_dout, m_ready);
endinterface

// File: rtl/capture_readout.sv
// capture_readout: streams BRAM samples 0..length-1 to a host link through a 2-entry buffer
module capture_readout #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W:0]   length_i,
  capture_readout_if.master bus,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W:0]   sent_count_o
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(1) << ADDR_W;
  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d, ptr_q, ptr_d, sent_q, sent_d;
  logic [DATA_W-1:0] mem_q [2];
  logic              wr_q, rd_q, infl_q, infl_d, done_q, done_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              en, xfer, push, pop, start_ok, finish, flush;
  // the read in flight counts as a buffered entry and is bypassed straight to the link when the FIFO is empty
  always_comb begin
    bus.m_valid = cnt_q != 2'd0 || infl_q;
    bus.m_data = cnt_q != 2'd0 ? mem_q[rd_q] : infl_q ? bus.bram_dout : '0;
    xfer = bus.m_valid && bus.m_ready;
    pop = xfer && cnt_q != 2'd0;
    push = infl_q && !(xfer && cnt_q == 2'd0);
    en = state_q == READ && (3'(cnt_q) + 3'(infl_q)) < 3'd2 && ptr_q < len_q;
    bus.bram_en = en;
    bus.bram_addr = ptr_q[ADDR_W] ? '1 : ptr_q[ADDR_W-1:0];
    start_ok = state_q == IDLE && start_i && !abort_i;
    flush = abort_i && state_q != IDLE;
    len_d = length_i > FULL ? FULL : length_i;
    ptr_d = start_ok ? '0 : ptr_q + (ADDR_W+1)'(en);
    sent_d = start_ok ? '0 : sent_q + (ADDR_W+1)'(xfer && sent_q < len_q);
    cnt_d = flush ? 2'd0 : cnt_q + 2'(push) - 2'(pop);
    infl_d = flush ? 1'b0 : en;
    finish = cnt_d == 2'd0 && !infl_d;
    state_d = state_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start_ok) begin
        state_d = len_d == '0 ? IDLE : READ;
        done_d = len_d == '0;
      end
      READ: state_d = ptr_d == len_q ? DRAIN : READ;
      DRAIN: if (finish) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      done_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      len_q <= '0;
      ptr_q <= '0;
      sent_q <= '0;
      cnt_q <= '0;
      infl_q <= 1'b0;
      done_q <= 1'b0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      state_q <= state_d;
      len_q <= start_ok ? len_d : len_q;
      ptr_q <= ptr_d;
      sent_q <= sent_d;
      cnt_q <= cnt_d;
      infl_q <= infl_d;
      done_q <= done_d;
      wr_q <= flush ? 1'b0 : wr_q ^ push;
      rd_q <= flush ? 1'b0 : rd_q ^ pop;
      if (push) mem_q[wr_q] <= bus.bram_dout;
    end
  end
  assign busy_o = state_q != IDLE;
  assign done_o = done_q;
  assign sent_count_o = sent_q;
endmodule

// File: tb/tb_capture_readout.sv
// tb_capture_readout: random and directed readouts checked against the expected sample stream mem[0..len-1]
module tb_capture_readout;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;
  logic clk = 1'b0;
  logic resetn, start, abort;
  logic [AW:0] length;
  logic busy, done;
  logic [AW:0] sent_count;
  logic [DW-1:0] mem [DEPTH];
  int n_chk = 0, n_fail = 0;
  int cyc_n = 0, issued, delivered, dones, exp_len;
  int s_c, first_x, last_x, done_c;
  bit saw_valid, saw_busy, prev_stall;
  logic [DW-1:0] prev_data;
  capture_readout_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  capture_readout #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .resetn(resetn), .start_i(start), .abort_i(abort), .length_i(length),
    .bus(bus), .busy_o(busy), .done_o(done), .sent_count_o(sent_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.bram_en) bus.bram_dout <= mem[bus.bram_addr];
  task automatic chk(input string tag, input longint got, input longint want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    if (bus.bram_en) begin
      chk("en_room", longint'(issued - delivered < 2), 1);
      chk("en_addr", longint'(bus.bram_addr), issued);
      chk("en_limit", longint'(issued < exp_len), 1);
      issued++;
    end
    if (prev_stall) begin
      chk("hold_valid", longint'(bus.m_valid), 1);
      chk("hold_data", longint'(bus.m_data), longint'(prev_data));
    end
    if (bus.m_valid && bus.m_ready) begin
      if (delivered < exp_len) chk("data", longint'(bus.m_data), longint'(mem[delivered]));
      else chk("extra_xfer", delivered + 1, exp_len);
      if (first_x < 0) first_x = cyc_n;
      last_x = cyc_n;
      delivered++;
    end
    if (done) begin
      dones++;
      done_c = cyc_n;
    end
    saw_valid |= bus.m_valid;
    saw_busy |= busy;
    prev_stall = bus.m_valid && !bus.m_ready;
    prev_data = bus.m_data;
    @(posedge clk);
    #1;
    cyc_n++;
  endtask
  task automatic clear_model(input int len);
    issued = 0;
    delivered = 0;
    dones = 0;
    first_x = -1;
    last_x = -1;
    done_c = -1;
    saw_valid = 0;
    saw_busy = 0;
    prev_stall = 0;
    exp_len = len > DEPTH ? DEPTH : len;
  endtask
  // mode 0: ready held high, 1: ready pattern 1,0,0,1, 2: random ready plus ignored start pulses
  task automatic run(input int len, input int mode, input int abort_at);
    int k = 0;
    bit aborted = 0;
    clear_model(len);
    bus.m_ready = 1'b1;
    start = 1'b1;
    length = (AW+1)'(len);
    s_c = cyc_n;
    cyc();
    start = 1'b0;
    while (k < 4 * exp_len + 20 && dones == 0 && !aborted) begin
      if (abort_at >= 0 && delivered >= abort_at) begin
        bus.m_ready = 1'b0;
        repeat (3) cyc();
        chk("abort_full", issued - delivered, 2);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        prev_stall = 0;
        aborted = 1;
        chk("abort_valid", longint'(bus.m_valid), 0);
        chk("abort_busy", longint'(busy), 0);
        chk("abort_sent", longint'(sent_count), abort_at);
        repeat (4) cyc();
        chk("abort_no_done", dones, 0);
      end else begin
        bus.m_ready = mode == 0 ? 1'b1 : mode == 1 ? (k % 4 == 0 || k % 4 == 3) : 1'($urandom);
        if (mode == 2 && delivered < exp_len && $urandom_range(0, 5) == 0) begin
          start = 1'b1;
          length = (AW+1)'($urandom);
        end
        cyc();
        start = 1'b0;
        k++;
      end
    end
    if (!aborted) begin
      chk("done_seen", dones, 1);
      chk("xfers", delivered, exp_len);
      chk("issued", issued, exp_len);
      chk("sent", longint'(sent_count), exp_len);
      if (exp_len == 0) begin
        chk("len0_done_at", done_c, s_c + 1);
        chk("len0_valid", longint'(saw_valid), 0);
        chk("len0_busy", longint'(saw_busy), 0);
      end else begin
        chk("done_after_last", done_c, last_x + 1);
        if (mode == 0) begin
          chk("first_latency", first_x, s_c + 2);
          chk("back_to_back", last_x - first_x + 1, exp_len);
        end
      end
      bus.m_ready = 1'b1;
      cyc();
      chk("busy_end", longint'(busy), 0);
      chk("single_done", dones, 1);
    end
  endtask
  initial begin
    resetn = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    length = '0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    clear_model(0);
    #12;
    chk("rst_valid", longint'(bus.m_valid), 0);
    chk("rst_en", longint'(bus.bram_en), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_sent", longint'(sent_count), 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    run(5, 0, -1);
    run(8, 1, -1);
    run(0, 0, -1);
    run(DEPTH, 0, -1);
    run(300, 0, -1);
    run(8, 0, 3);
    run(2, 0, -1);
    clear_model(0);
    start = 1'b1;
    abort = 1'b1;
    length = 9'd5;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    repeat (4) cyc();
    chk("start_abort_busy", longint'(saw_busy), 0);
    chk("start_abort_reads", issued, 0);
    chk("start_abort_done", dones, 0);
    clear_model(30);
    start = 1'b1;
    length = 9'd30;
    cyc();
    start = 1'b0;
    repeat (5) cyc();
    resetn = 1'b0;
    #2;
    chk("mid_rst_valid", longint'(bus.m_valid), 0);
    chk("mid_rst_data", longint'(bus.m_data), 0);
    chk("mid_rst_en", longint'(bus.bram_en), 0);
    chk("mid_rst_addr", longint'(bus.bram_addr), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_done", longint'(done), 0);
    chk("mid_rst_sent", longint'(sent_count), 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    clear_model(0);
    repeat (5) cyc();
    chk("post_rst_valid", longint'(saw_valid), 0);
    chk("post_rst_reads", issued, 0);
    run(4, 0, -1);
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
      run(r == 5 ? 20 : int'($urandom_range(1, 40)), r == 5 ? 0 : 2, r == 5 ? int'($urandom_range(1, 10)) : -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
